vec_add_tree: RTL
=================

// Module: vec_add_tree
// PURPOSE
//  N-input, element-wise signed vector adder with full valid/ready backpressure.
//  Sums NUM_IN input vector streams of VECTOR_LEN elements through a pipelined
//  binary adder tree, with optional output saturation.
//  Sits in the wrd datapath where several conv/filter channel streams merge
//  before the dense/argmax stages.
// PARAMETERS
//  NUM_IN      4   number of input streams, >= 2
//  VECTOR_LEN  13  elements per vector
//  BW_I        32  signed input element width
//  BW_O        34  signed output element width, >= 2
//  SATURATE    1   1: clamp to BW_O range; 0: two's-complement wrap (truncate)
// PORTS
//  clk_i    in   1                        clock
//  rst_i    in   1                        reset
//  data_i   in   NUM_IN*VECTOR_LEN*BW_I   stream k at [k*VL*BW_I +: VL*BW_I]; elem e at +e*BW_I
//  valid_i  in   NUM_IN                   per-stream valid
//  last_i   in   NUM_IN                   per-stream end-of-frame
//  ready_o  out  NUM_IN                   per-stream ready
//  data_o   out  VECTOR_LEN*BW_O          summed vector, elem e at [e*BW_O +: BW_O]
//  valid_o  out  1                        output valid
//  last_o   out  1                        OR of the accepted beat's last_i bits
//  sat_o    out  1                        some element of this beat was clamped (0 when SATURATE=0)
//  ready_i  in   1                        downstream ready
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-high.
//  - Reset: every stage valid=0; data/last/sat regs=0; so valid_o=0, data_o=0, last_o=0, sat_o=0.
//    Asserting rst_i mid-operation drops all in-flight beats; nothing is replayed.
//  - Join: a beat is accepted only when &valid_i && s0_ready.
//    ready_o[k] = (&valid_i) & s0_ready for all k, so all streams transfer together.
//    A lone valid stream waits; it is never consumed alone.
//  - Pipeline: LEVELS = $clog2(NUM_IN) adder levels, each registered, plus one
//    output/saturation stage. Latency = LEVELS+1 cycles, accept to valid_o
//    (NUM_IN=4: 3 cycles).
//  - Stage regs: valid, VECTOR_LEN partial sums, last, sat.
//  - Stall: stage k loads when !valid_k | ready_{k+1}. Last stage loads when
//    !valid_o | ready_i. Bubbles collapse. Throughput 1 beat/clk when ready_i=1.
//  - Output data holds stable while valid_o & !ready_i.
//  - Odd tree nodes pass through unchanged, e.g. NUM_IN=3: level 0 = {a+b, c}.
//  - Width: internal width W = BW_I + $clog2(NUM_IN) at every level, sign-extended,
//    so tree sums never overflow.
//  - Final stage:
//    - If BW_O >= W: sign-extend, sat_o=0.
//    - Else if SATURATE=1: clamp to [-2^(BW_O-1), 2^(BW_O-1)-1]; sat_o=1 if any element clamped.
//    - Else: keep the low BW_O bits, sat_o=0.
//  - last: OR of last_i at accept, carried beside the data. Differing last_i bits
//    are not an error.
//  - Simultaneous events: accept and output pop in the same cycle at a full pipe
//    sustain throughput.
//  - A ready_i deassert stalls stages back to s0 only as bubbles run out.
// STRUCTURE
//  - Package wrd_pkg:
//    - function sat_clip(value, W, BW_O) returning {clipped value, sat flag}
//    - localparam helpers: tree_levels(NUM_IN), nodes_at_level(n, l)
//  - One sub-module, vec_add_stage: one registered tree level with parameter
//    NODES_IN, per-element adders, valid/ready stall logic.
//  - The top generates LEVELS instances plus the saturation/output register stage.
// TESTING
//  1. Reset: hold rst_i with valid_i=all 1 -> ready_o=0, valid_o=0, data_o=0.
//     Release -> first beat appears after 3 clk (NUM_IN=4).
//  2. Sum: NUM_IN=4, all elems {1,-2,100,-7} -> all output elems 92.
//     Streaming 20 beats with ready_i=1 -> 20 outputs on 20 consecutive cycles, in order.
//  3. Join: valid_i=4'b0111 for 5 clk -> ready_o=0, no output.
//     valid_i=4'b1111 -> accept once.
//  4. Backpressure: ready_i=0 for 6 clk during a stream -> valid_o/data_o stable,
//     at most LEVELS+1 beats buffered, ready_o drops.
//     Release -> no loss, no duplication.
//  5. Saturation: BW_I=32, BW_O=32, SATURATE=1, all elems 2^31-1 -> data_o=2^31-1, sat_o=1.
//     All -2^31 -> -2^31, sat_o=1.
//     SATURATE=0, same max inputs -> low 32 bits of 4*(2^31-1) = -4, sat_o=0.
//  6. last / odd width: NUM_IN=3, last_i=3'b010 on beat 7 -> last_o=1 on output beat 7 only.
//     Inputs {5,6,7} -> 18.

Source files
------------

// File: rtl/wrd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wrd_pkg
// Description : Shared helpers for the wrd datapath adder tree: tree sizing
//               functions and the output clamp function.
// Revision    : 1.0  initial release
// ============================================================================
package wrd_pkg;

    // Widest internal value the clamp helper accepts.
    localparam int SAT_MAX_W = 128;

    typedef logic signed [SAT_MAX_W-1:0] wide_t;

    typedef struct packed {
        logic signed [SAT_MAX_W-1:0] value;
        logic                        sat;
    } sat_res_t;

    // Number of registered adder levels needed to reduce n inputs to one.
    function automatic int tree_levels(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Number of nodes entering level l (level 0 sees all n inputs).
    // Odd counts round up because the unpaired node passes straight through.
    function automatic int nodes_at_level(input int n, input int l);
        int r;
        r = n;
        for (int i = 0; i < l; i++) begin
            r = (r + 1) / 2;
        end
        return r;
    endfunction

    // Clamp a sign-extended W-bit value into the signed bw_o range.
    // No clamping is possible when bw_o >= w, so the flag stays low there.
    function automatic sat_res_t sat_clip(input wide_t value, input int w, input int bw_o);
        sat_res_t r;
        wide_t    hi;
        wide_t    lo;
        hi      = (wide_t'(1) <<< (bw_o - 1)) - wide_t'(1);
        lo      = ~hi;
        r.value = value;
        r.sat   = 1'b0;
        if (bw_o < w) begin
            if (value > hi) begin
                r.value = hi;
                r.sat   = 1'b1;
            end else if (value < lo) begin
                r.value = lo;
                r.sat   = 1'b1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_add_stage.sv
`default_nettype none
// ============================================================================
// Module      : vec_add_stage
// Description : One registered level of the vector adder tree. Adds node
//               pairs element-wise; an unpaired last node passes through.
//               Loads whenever empty or when the next level takes its beat.
// Ports       : clk_i/rst_i  clock, asynchronous active-high reset
//               i_valid/o_ready/i_data/i_last   upstream side
//               o_valid/i_ready/o_data/o_last   downstream side
//               Node n element e sits at [(n*VECTOR_LEN+e)*W +: W].
// Revision    : 1.0  initial release
// ============================================================================
module vec_add_stage
    import wrd_pkg::*;
#(
    parameter  int NODES_IN   = 4,
    parameter  int VECTOR_LEN = 13,
    parameter  int W          = 34,
    localparam int NODES_OUT  = nodes_at_level(NODES_IN, 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [NODES_IN*VECTOR_LEN*W-1:0]  i_data,
    input  logic                              i_last,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [NODES_OUT*VECTOR_LEN*W-1:0] o_data,
    output logic                              o_last
);

    logic                              r_valid;
    logic                              r_last;
    logic [NODES_OUT*VECTOR_LEN*W-1:0] r_data;
    logic [NODES_OUT*VECTOR_LEN*W-1:0] w_sum;
    logic                              w_load;

    // An empty register can always take a beat, so bubbles collapse.
    assign w_load  = ~r_valid | i_ready;
    assign o_ready = w_load;

    for (genvar n = 0; n < NODES_OUT; n++) begin : g_node
        for (genvar e = 0; e < VECTOR_LEN; e++) begin : g_elem
            localparam int c_a = ((2 * n) * VECTOR_LEN + e) * W;
            localparam int c_o = (n * VECTOR_LEN + e) * W;
            if (2 * n + 1 < NODES_IN) begin : g_pair
                localparam int c_b = ((2 * n + 1) * VECTOR_LEN + e) * W;
                // W already carries enough headroom for the full tree.
                assign w_sum[c_o +: W] = i_data[c_a +: W] + i_data[c_b +: W];
            end else begin : g_pass
                assign w_sum[c_o +: W] = i_data[c_a +: W];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_sum;
                r_last <= i_last;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/vec_add_tree.sv
`default_nettype none
// ============================================================================
// Module      : vec_add_tree
// Description : NUM_IN-input element-wise signed vector adder. All input
//               streams join into one beat, pass through a pipelined binary
//               adder tree and a final saturate/wrap output register.
//               Latency is tree_levels(NUM_IN)+1 cycles, 1 beat/clk.
// Ports       : clk_i, rst_i           clock, asynchronous active-high reset
//               data_i/valid_i/last_i  per-stream inputs (stream k at
//                                      [k*VECTOR_LEN*BW_I +: VECTOR_LEN*BW_I])
//               ready_o                per-stream ready (all equal)
//               data_o/valid_o/last_o  summed vector, elem e at [e*BW_O +: BW_O]
//               sat_o                  some element of the beat was clamped
//               ready_i                downstream ready
// Revision    : 1.0  initial release
// ============================================================================
module vec_add_tree
    import wrd_pkg::*;
#(
    parameter int NUM_IN     = 4,
    parameter int VECTOR_LEN = 13,
    parameter int BW_I       = 32,
    parameter int BW_O       = 34,
    parameter int SATURATE   = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_IN*VECTOR_LEN*BW_I-1:0] data_i,
    input  logic [NUM_IN-1:0]                 valid_i,
    input  logic [NUM_IN-1:0]                 last_i,
    output logic [NUM_IN-1:0]                 ready_o,
    output logic [VECTOR_LEN*BW_O-1:0]        data_o,
    output logic                              valid_o,
    output logic                              last_o,
    output logic                              sat_o,
    input  logic                              ready_i
);

    localparam int c_levels = tree_levels(NUM_IN);
    localparam int c_w      = BW_I + c_levels;

    logic [NUM_IN*VECTOR_LEN*c_w-1:0] w_s0_data;
    logic                             w_join;
    logic                             w_s0_ready;
    logic [VECTOR_LEN*c_w-1:0]        w_tree_data;
    logic                             w_tree_valid;
    logic                             w_tree_last;
    logic                             w_out_load;
    logic [VECTOR_LEN*BW_O-1:0]       w_res_data;
    logic [VECTOR_LEN-1:0]            w_sat_vec;

    logic                             r_valid_o;
    logic                             r_last_o;
    logic                             r_sat_o;
    logic [VECTOR_LEN*BW_O-1:0]       r_data_o;

    // Streams only move together: a lone valid stream is never consumed.
    assign w_join  = &valid_i;
    // Held low while in reset so no stream believes it transferred.
    assign ready_o = {NUM_IN{w_join & w_s0_ready & ~rst_i}};

    for (genvar k = 0; k < NUM_IN; k++) begin : g_ext_stream
        for (genvar e = 0; e < VECTOR_LEN; e++) begin : g_ext_elem
            assign w_s0_data[(k*VECTOR_LEN+e)*c_w +: c_w] =
                c_w'($signed(data_i[(k*VECTOR_LEN+e)*BW_I +: BW_I]));
        end
    end

    for (genvar l = 0; l < c_levels; l++) begin : g_level
        localparam int c_nin  = nodes_at_level(NUM_IN, l);
        localparam int c_nout = nodes_at_level(NUM_IN, l + 1);

        logic [c_nin*VECTOR_LEN*c_w-1:0]  w_in_data;
        logic                             w_in_valid;
        logic                             w_in_last;
        logic                             w_in_ready;
        logic [c_nout*VECTOR_LEN*c_w-1:0] w_out_data;
        logic                             w_out_valid;
        logic                             w_out_last;
        logic                             w_out_ready;

        if (l == 0) begin : g_first
            assign w_in_data  = w_s0_data;
            assign w_in_valid = w_join;
            assign w_in_last  = |last_i;
            assign w_s0_ready = w_in_ready;
        end else begin : g_chain
            assign w_in_data  = g_level[l-1].w_out_data;
            assign w_in_valid = g_level[l-1].w_out_valid;
            assign w_in_last  = g_level[l-1].w_out_last;
        end

        if (l == c_levels - 1) begin : g_tail
            assign w_out_ready  = w_out_load;
            assign w_tree_data  = w_out_data;
            assign w_tree_valid = w_out_valid;
            assign w_tree_last  = w_out_last;
        end else begin : g_mid
            assign w_out_ready = g_level[l+1].w_in_ready;
        end

        vec_add_stage #(
            .NODES_IN   (c_nin),
            .VECTOR_LEN (VECTOR_LEN),
            .W          (c_w)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .i_valid (w_in_valid),
            .o_ready (w_in_ready),
            .i_data  (w_in_data),
            .i_last  (w_in_last),
            .o_valid (w_out_valid),
            .i_ready (w_out_ready),
            .o_data  (w_out_data),
            .o_last  (w_out_last)
        );
    end

    for (genvar e = 0; e < VECTOR_LEN; e++) begin : g_out
        logic signed [c_w-1:0] w_elem;
        assign w_elem = w_tree_data[e*c_w +: c_w];
        if (BW_O >= c_w) begin : g_sext
            assign w_res_data[e*BW_O +: BW_O] = BW_O'(w_elem);
            assign w_sat_vec[e]               = 1'b0;
        end else if (SATURATE != 0) begin : g_sat
            sat_res_t w_res;
            assign w_res                      = sat_clip(wide_t'(w_elem), c_w, BW_O);
            assign w_res_data[e*BW_O +: BW_O] = w_res.value[BW_O-1:0];
            assign w_sat_vec[e]               = w_res.sat;
        end else begin : g_wrap
            assign w_res_data[e*BW_O +: BW_O] = w_elem[BW_O-1:0];
            assign w_sat_vec[e]               = 1'b0;
        end
    end

    // Output register holds its beat while valid_o & !ready_i.
    assign w_out_load = ~r_valid_o | ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_o <= 1'b0;
            r_last_o  <= 1'b0;
            r_sat_o   <= 1'b0;
            r_data_o  <= '0;
        end else if (w_out_load) begin
            r_valid_o <= w_tree_valid;
            if (w_tree_valid) begin
                r_data_o <= w_res_data;
                r_last_o <= w_tree_last;
                r_sat_o  <= |w_sat_vec;
            end
        end
    end

    assign data_o  = r_data_o;
    assign valid_o = r_valid_o;
    assign last_o  = r_last_o;
    assign sat_o   = r_sat_o;

endmodule
`default_nettype wire
